irq_controller: RTL and testbench

Interrupt controller for the 8-bit microprocessor, sitting beside program_sequencer. It latches rising edges on four interrupt request lines and masks and prioritises them. It asks the sequencer to redirect fetch to a per-source vector, captures the return address, and hands that address back when the service routine executes its return-from-interrupt. Interrupts do not nest: one is serviced at a time.

---
 rtl/irq_controller.sv | 96 +++++++++
 tb/tb_irq_controller.sv | 129 ++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
// irq_controller: edge-latching, maskable, fixed-priority interrupt controller for the 8-bit CPU
//
// Ports:
//   clk        - system clock, all state on rising edge
//   reset_n    - asynchronous active-low reset
//   irq        - four request lines, bit 0 highest priority
//   mask_wr    - load mask from mask_data at this edge
//   mask_data  - new mask, 1 = source disabled
//   int_hold   - current instruction forbids interrupt acceptance this cycle
//   rti        - current instruction is return-from-interrupt
//   pc         - current program counter
//   int_take   - sequencer loads pm_addr = int_vector this cycle
//   int_vector - vector address of the source being serviced
//   int_ret    - sequencer loads pm_addr = ret_addr this cycle
//   ret_addr   - saved return address
//   int_active - high from the take cycle until int_ret
//   active_id  - index of the source being serviced
//   pending    - pending latches, for status read
module irq_controller #(
   parameter logic [7:0] VEC_BASE = 8'hF0
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] irq,
   input  logic       mask_wr,
   input  logic [3:0] mask_data,
   input  logic       int_hold,
   input  logic       rti,
   input  logic [7:0] pc,
   output logic       int_take,
   output logic [7:0] int_vector,
   output logic       int_ret,
   output logic [7:0] ret_addr,
   output logic       int_active,
   output logic [1:0] active_id,
   output logic [3:0] pending
);
   typedef enum logic [1:0] {IDLE, TAKE, SERVICE} state_t;
   state_t     state_q, state_d;
   logic [3:0] pending_q, pending_d;
   logic [3:0] mask_q, mask_d;
   logic [3:0] irq_prev_q;
   logic [1:0] active_id_q, active_id_d;
   logic [7:0] ret_addr_q, ret_addr_d;
   logic [3:0] rise, eligible, clr;
   logic [1:0] winner;
   always_comb begin
      rise        = irq & ~irq_prev_q;
      eligible    = pending_q & ~mask_q;
      winner      = eligible[0] ? 2'd0 : eligible[1] ? 2'd1 : eligible[2] ? 2'd2 : 2'd3;
      state_d     = state_q;
      active_id_d = active_id_q;
      ret_addr_d  = ret_addr_q;
      clr         = 4'b0000;
      case (state_q)
         IDLE: if (|eligible && !int_hold) begin
            state_d     = TAKE;
            active_id_d = winner;
         end
         TAKE: begin
            state_d    = SERVICE;
            ret_addr_d = pc + 8'd1;
            clr        = 4'b0001 << active_id_q;
         end
         SERVICE: if (rti) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // a new edge on the bit being cleared wins, so it is OR-ed in last
      pending_d = (pending_q & ~clr) | rise;
      mask_d    = mask_wr ? mask_data : mask_q;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         pending_q   <= 4'h0;
         mask_q      <= 4'hF;
         irq_prev_q  <= 4'h0;
         active_id_q <= 2'd0;
         ret_addr_q  <= 8'h00;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         mask_q      <= mask_d;
         irq_prev_q  <= irq;
         active_id_q <= active_id_d;
         ret_addr_q  <= ret_addr_d;
      end
   end
   assign int_take   = (state_q == TAKE);
   assign int_active = (state_q == TAKE) || (state_q == SERVICE);
   assign int_ret    = rti && (state_q == SERVICE);
   assign int_vector = VEC_BASE + {4'b0000, active_id_q, 2'b00};
   assign ret_addr   = ret_addr_q;
   assign active_id  = active_id_q;
   assign pending    = pending_q;
endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed self-checking bench for irq_controller
module tb_irq_controller;
   logic       clk, reset_n, mask_wr, int_hold, rti;
   logic [3:0] irq, mask_data;
   logic [7:0] pc;
   logic       int_take, int_ret, int_active;
   logic [7:0] int_vector, ret_addr;
   logic [1:0] active_id;
   logic [3:0] pending;
   int errors = 0;
   int checks = 0;

   irq_controller dut (
      .clk(clk), .reset_n(reset_n), .irq(irq), .mask_wr(mask_wr), .mask_data(mask_data),
      .int_hold(int_hold), .rti(rti), .pc(pc), .int_take(int_take), .int_vector(int_vector),
      .int_ret(int_ret), .ret_addr(ret_addr), .int_active(int_active), .active_id(active_id),
      .pending(pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      reset_n = 1'b0; irq = 4'h0; mask_wr = 1'b0; mask_data = 4'h0;
      int_hold = 1'b0; rti = 1'b0; pc = 8'h00;
      #2;
      chk("rst_take", int_take, 0);
      chk("rst_active", int_active, 0);
      chk("rst_pending", pending, 8'h0);
      chk("rst_ret_addr", ret_addr, 8'h00);
      chk("rst_active_id", active_id, 0);
      tick; reset_n = 1'b1;
      mask_wr = 1'b1; mask_data = 4'h0;
      tick; mask_wr = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("quiet_take", int_take, 0);
      end
      // single source irq[2]
      pc = 8'h23; irq = 4'b0100;
      tick; chk("t1_pending_set", pending, 8'h4); chk("t1_take_early", int_take, 0);
      irq = 4'b0000;
      tick; chk("t1_take", int_take, 1); chk("t1_vector", int_vector, 8'hF8);
      chk("t1_active", int_active, 1); chk("t1_id", active_id, 2);
      tick; chk("t1_ret_addr", ret_addr, 8'h24); chk("t1_pending_clr", pending, 8'h0);
      chk("t1_take_once", int_take, 0);
      rti = 1'b1; #1; chk("t1_int_ret", int_ret, 1);
      tick; rti = 1'b0; #1; chk("t1_ret_low", int_ret, 0); chk("t1_idle", int_active, 0);
      // simultaneous irq[3] and irq[1]
      irq = 4'b1010;
      tick; chk("t2_pending", pending, 8'hA);
      tick; chk("t2_id", active_id, 1); chk("t2_vector", int_vector, 8'hF4);
      irq = 4'b0000;
      tick; chk("t2_pending_left", pending, 8'h8);
      rti = 1'b1; #1; chk("t2_int_ret", int_ret, 1);
      tick; rti = 1'b0; #1; chk("t2_ret_low", int_ret, 0); chk("t2_gap_take", int_take, 0);
      tick; chk("t2_second_take", int_take, 1); chk("t2_second_vector", int_vector, 8'hFC);
      tick; chk("t2_pending_empty", pending, 8'h0);
      rti = 1'b1; tick; rti = 1'b0;
      // masked source released by mask write
      mask_wr = 1'b1; mask_data = 4'b0001;
      tick; mask_wr = 1'b0; irq = 4'b0001;
      tick; chk("t3_pending", pending, 8'h1);
      tick; chk("t3_masked_take", int_take, 0);
      mask_wr = 1'b1; mask_data = 4'h0;
      tick; mask_wr = 1'b0; chk("t3_write_edge_take", int_take, 0);
      tick; chk("t3_take", int_take, 1); chk("t3_vector", int_vector, 8'hF0);
      irq = 4'b0000;
      tick; rti = 1'b1; tick; rti = 1'b0;
      // int_hold for three cycles, then mask write during TAKE
      int_hold = 1'b1; irq = 4'b0100;
      tick; chk("t4_pending", pending, 8'h4);
      tick; chk("t4_hold1", int_take, 0);
      tick; chk("t4_hold2", int_take, 0);
      tick; chk("t4_hold3", int_take, 0);
      int_hold = 1'b0;
      tick; chk("t4_take", int_take, 1);
      mask_wr = 1'b1; mask_data = 4'hF; int_hold = 1'b1; irq = 4'b0001;
      tick; mask_wr = 1'b0; int_hold = 1'b0; irq = 4'b0000;
      chk("t4_id_frozen", active_id, 2); chk("t4_vector_frozen", int_vector, 8'hF8);
      chk("t4_service", int_active, 1); chk("t4_pending_masked", pending, 8'h1);
      rti = 1'b1; tick; rti = 1'b0;
      // rti in IDLE, re-edge during service, ret_addr wrap
      rti = 1'b1; mask_wr = 1'b1; mask_data = 4'b0001; #1;
      chk("t5_rti_idle", int_ret, 0);
      tick; rti = 1'b0; mask_wr = 1'b0; pc = 8'hFF; irq = 4'b0010;
      tick; chk("t5_pending", pending, 8'h3);
      tick; chk("t5_take", int_take, 1); chk("t5_id", active_id, 1);
      irq = 4'b0000;
      tick; chk("t5_wrap", ret_addr, 8'h00); chk("t5_pending_clr", pending, 8'h1);
      irq = 4'b0010;
      tick; chk("t5_reedge", pending, 8'h3); chk("t5_no_retake", int_take, 0);
      rti = 1'b1; #1; chk("t5_int_ret", int_ret, 1);
      tick; rti = 1'b0;
      tick; chk("t5_retake", int_take, 1); chk("t5_retake_id", active_id, 1);
      tick; chk("t5_service", int_active, 1);
      // asynchronous reset mid-SERVICE
      rti = 1'b1; #2; reset_n = 1'b0; #1;
      chk("t6_active", int_active, 0); chk("t6_take", int_take, 0); chk("t6_ret", int_ret, 0);
      rti = 1'b0; irq = 4'b0000;
      tick; reset_n = 1'b1;
      tick; chk("t6_pending", pending, 8'h0); chk("t6_ret_addr", ret_addr, 8'h00);
      irq = 4'b0001;
      tick; chk("t6_pending_set", pending, 8'h1);
      tick; chk("t6_mask_all", int_take, 0);
      tick; chk("t6_mask_all2", int_take, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
